// File: rtl/eth_pkg.sv
// Shared constants and types for the AXI Ethernet Lite MDIO link poller.
package eth_pkg;

   // AXI Ethernet Lite MDIO register byte offsets
   localparam int unsigned MDIO_ADDR = 32'h0000_07E4;
   localparam int unsigned MDIO_WR   = 32'h0000_07E8;
   localparam int unsigned MDIO_RD   = 32'h0000_07EC;
   localparam int unsigned MDIO_CTRL = 32'h0000_07F0;

   // MDIOCTRL bit positions
   localparam int unsigned CTRL_BUSY = 0;
   localparam int unsigned CTRL_EN   = 3;

   // PHY Basic Status Register (register 1) bit positions
   localparam int unsigned BSR_LINK    = 2;
   localparam int unsigned BSR_AN_DONE = 5;

   localparam logic [4:0] PHY_REG_BSR = 5'd1;

   // Enable plus busy/start: kicks off the transaction programmed in MDIOADDR
   localparam logic [31:0] MDIO_CTRL_GO = (32'd1 << CTRL_EN) | (32'd1 << CTRL_BUSY);

   typedef enum logic [3:0] {
      StIdle,
      StWrAddr,
      StGap1,
      StWrCtrl,
      StGap2,
      StBusyRd,
      StBusyWait,
      StDataRd,
      StDataWait,
      StUpdate,
      StFail
   } poll_state_e;

   typedef enum logic [1:0] {
      SqIdle,
      SqGap,
      SqWait
   } seq_state_e;

   // MDIOADDR word for a read: op bit 10, PHY address [9:5], register [4:0]
   function automatic logic [31:0] mdio_rd_word(input logic [4:0] phy, input logic [4:0] regad);
      return {21'd0, 1'b1, phy, regad};
   endfunction

endpackage

// File: rtl/mdio_cmd_seq.sv
// Issues one write or read on the axi_eth command port; writes are followed by
// a fixed idle gap, reads wait for read_done under a timeout.
module mdio_cmd_seq
   import eth_pkg::*;
#(
   parameter int unsigned P_AXI_ADDR_WIDTH = 13,
   parameter int unsigned P_AXI_DATA_WIDTH = 32,
   parameter int unsigned P_WR_GAP         = 16,
   parameter int unsigned P_TIMEOUT        = 4096
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic                        wr,
   input  logic [P_AXI_ADDR_WIDTH-1:0] addr,
   input  logic [P_AXI_DATA_WIDTH-1:0] wdata,
   output logic                        done,
   output logic                        timeout,
   output logic [P_AXI_DATA_WIDTH-1:0] rdata,
   output logic                        do_axi_write,
   output logic [P_AXI_ADDR_WIDTH-1:0] axi_write_addr,
   output logic [P_AXI_DATA_WIDTH-1:0] axi_write_data,
   output logic                        do_axi_read,
   output logic [P_AXI_ADDR_WIDTH-1:0] axi_read_addr,
   input  logic [P_AXI_DATA_WIDTH-1:0] axi_read_data,
   input  logic                        read_done
);

   localparam int unsigned CntMax = (P_TIMEOUT > P_WR_GAP) ? P_TIMEOUT : P_WR_GAP;
   localparam int unsigned CntW   = $clog2(CntMax + 1);

   seq_state_e                  state_q, state_d;
   logic [CntW-1:0]             cnt_q, cnt_d;
   logic                        do_wr_q, do_wr_d;
   logic                        do_rd_q, do_rd_d;
   logic [P_AXI_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
   logic [P_AXI_DATA_WIDTH-1:0] wr_data_q, wr_data_d;
   logic [P_AXI_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;

   assign do_axi_write   = do_wr_q;
   assign axi_write_addr = wr_addr_q;
   assign axi_write_data = wr_data_q;
   assign do_axi_read    = do_rd_q;
   assign axi_read_addr  = rd_addr_q;
   assign rdata          = axi_read_data;

   // Next state: the strobe cycle is the first Gap/Wait cycle, with cnt_q = 0
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      do_wr_d   = 1'b0;
      do_rd_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      rd_addr_d = rd_addr_q;
      done      = 1'b0;
      timeout   = 1'b0;
      unique case (state_q)
         SqIdle: begin
            if (start) begin
               cnt_d = '0;
               if (wr) begin
                  do_wr_d   = 1'b1;
                  wr_addr_d = addr;
                  wr_data_d = wdata;
                  state_d   = SqGap;
               end else begin
                  do_rd_d   = 1'b1;
                  rd_addr_d = addr;
                  state_d   = SqWait;
               end
            end
         end
         SqGap: begin
            if (cnt_q == CntW'(P_WR_GAP)) begin
               done    = 1'b1;
               state_d = SqIdle;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         SqWait: begin
            if (read_done) begin
               done    = 1'b1;
               state_d = SqIdle;
            end else if (cnt_q == CntW'(P_TIMEOUT - 1)) begin
               timeout = 1'b1;
               state_d = SqIdle;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         default: state_d = SqIdle;
      endcase
   end

   // State and registered command outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= SqIdle;
         cnt_q     <= '0;
         do_wr_q   <= 1'b0;
         do_rd_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         rd_addr_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         do_wr_q   <= do_wr_d;
         do_rd_q   <= do_rd_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         rd_addr_q <= rd_addr_d;
      end
   end

endmodule

// File: rtl/mdio_link_poller.sv
// Periodically reads PHY register 1 over MDIO via axi_eth and publishes link status.
module mdio_link_poller
   import eth_pkg::*;
#(
   parameter int unsigned P_AXI_ADDR_WIDTH = 13,
   parameter int unsigned P_AXI_DATA_WIDTH = 32,
   parameter int unsigned P_PHY_ADDR       = 0,
   parameter int unsigned P_POLL_INTERVAL  = 1000000,
   parameter int unsigned P_WR_GAP         = 16,
   parameter int unsigned P_TIMEOUT        = 4096,
   parameter int unsigned P_BUSY_MAX       = 64
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        enable,
   input  logic                        force_poll,
   output logic                        do_axi_write,
   output logic [P_AXI_ADDR_WIDTH-1:0] axi_write_addr,
   output logic [P_AXI_DATA_WIDTH-1:0] axi_write_data,
   output logic                        do_axi_read,
   output logic [P_AXI_ADDR_WIDTH-1:0] axi_read_addr,
   input  logic [P_AXI_DATA_WIDTH-1:0] axi_read_data,
   input  logic                        read_done,
   output logic [15:0]                 phy_status,
   output logic                        link_up,
   output logic                        an_done,
   output logic                        status_valid,
   output logic                        link_change,
   output logic                        err,
   output logic                        busy
);

   localparam int unsigned IvlW  = $clog2(P_POLL_INTERVAL + 1);
   localparam int unsigned BcntW = $clog2(P_BUSY_MAX + 1);
   localparam logic [P_AXI_DATA_WIDTH-1:0] AddrWord =
      P_AXI_DATA_WIDTH'(mdio_rd_word(5'(P_PHY_ADDR), PHY_REG_BSR));

   poll_state_e                 state_q, state_d;
   logic [IvlW-1:0]             ivl_q, ivl_d;
   logic                        pend_q, pend_d;
   logic [BcntW-1:0]            bcnt_q, bcnt_d;
   logic [15:0]                 phy_q, phy_d;
   logic                        link_q, link_d;
   logic                        an_q, an_d;
   logic                        sv_q, sv_d;
   logic                        lc_q, lc_d;
   logic                        err_q, err_d;

   logic                        cmd_start, cmd_wr, cmd_done, cmd_timeout;
   logic [P_AXI_ADDR_WIDTH-1:0] cmd_addr;
   logic [P_AXI_DATA_WIDTH-1:0] cmd_wdata, cmd_rdata;
   logic                        unused_rdata;

   assign unused_rdata = ^cmd_rdata[P_AXI_DATA_WIDTH-1:16];

   assign phy_status   = phy_q;
   assign link_up      = link_q;
   assign an_done      = an_q;
   assign status_valid = sv_q;
   assign link_change  = lc_q;
   assign err          = err_q;
   assign busy         = (state_q != StIdle);

   mdio_cmd_seq #(
      .P_AXI_ADDR_WIDTH(P_AXI_ADDR_WIDTH),
      .P_AXI_DATA_WIDTH(P_AXI_DATA_WIDTH),
      .P_WR_GAP        (P_WR_GAP),
      .P_TIMEOUT       (P_TIMEOUT)
   ) u_cmd_seq (
      .clk           (clk),
      .rst           (rst),
      .start         (cmd_start),
      .wr            (cmd_wr),
      .addr          (cmd_addr),
      .wdata         (cmd_wdata),
      .done          (cmd_done),
      .timeout       (cmd_timeout),
      .rdata         (cmd_rdata),
      .do_axi_write  (do_axi_write),
      .axi_write_addr(axi_write_addr),
      .axi_write_data(axi_write_data),
      .do_axi_read   (do_axi_read),
      .axi_read_addr (axi_read_addr),
      .axi_read_data (axi_read_data),
      .read_done     (read_done)
   );

   // Poll sequencing; status outputs are loaded on entry to Update/Fail
   always_comb begin
      state_d   = state_q;
      ivl_d     = ivl_q;
      pend_d    = pend_q | force_poll;
      bcnt_d    = bcnt_q;
      phy_d     = phy_q;
      link_d    = link_q;
      an_d      = an_q;
      sv_d      = 1'b0;
      lc_d      = 1'b0;
      err_d     = err_q;
      cmd_start = 1'b0;
      cmd_wr    = 1'b0;
      cmd_addr  = '0;
      cmd_wdata = '0;
      unique case (state_q)
         StIdle: begin
            if (ivl_q != '0) ivl_d = ivl_q - IvlW'(1);
            if ((enable && (ivl_q == '0)) || pend_q || force_poll) begin
               pend_d  = 1'b0;
               state_d = StWrAddr;
            end
         end
         StWrAddr: begin
            cmd_start = 1'b1;
            cmd_wr    = 1'b1;
            cmd_addr  = P_AXI_ADDR_WIDTH'(MDIO_ADDR);
            cmd_wdata = AddrWord;
            bcnt_d    = '0;
            state_d   = StGap1;
         end
         StGap1: if (cmd_done) state_d = StWrCtrl;
         StWrCtrl: begin
            cmd_start = 1'b1;
            cmd_wr    = 1'b1;
            cmd_addr  = P_AXI_ADDR_WIDTH'(MDIO_CTRL);
            cmd_wdata = P_AXI_DATA_WIDTH'(MDIO_CTRL_GO);
            state_d   = StGap2;
         end
         StGap2: if (cmd_done) state_d = StBusyRd;
         StBusyRd: begin
            cmd_start = 1'b1;
            cmd_addr  = P_AXI_ADDR_WIDTH'(MDIO_CTRL);
            state_d   = StBusyWait;
         end
         StBusyWait: begin
            if (cmd_timeout) begin
               state_d = StFail;
               err_d   = 1'b1;
               link_d  = 1'b0;
               an_d    = 1'b0;
            end else if (cmd_done) begin
               if (!cmd_rdata[CTRL_BUSY]) begin
                  state_d = StDataRd;
               end else if (bcnt_q == BcntW'(P_BUSY_MAX - 1)) begin
                  state_d = StFail;
                  err_d   = 1'b1;
                  link_d  = 1'b0;
                  an_d    = 1'b0;
               end else begin
                  bcnt_d  = bcnt_q + BcntW'(1);
                  state_d = StBusyRd;
               end
            end
         end
         StDataRd: begin
            cmd_start = 1'b1;
            cmd_addr  = P_AXI_ADDR_WIDTH'(MDIO_RD);
            state_d   = StDataWait;
         end
         StDataWait: begin
            if (cmd_timeout) begin
               state_d = StFail;
               err_d   = 1'b1;
               link_d  = 1'b0;
               an_d    = 1'b0;
            end else if (cmd_done) begin
               state_d = StUpdate;
               phy_d   = cmd_rdata[15:0];
               link_d  = cmd_rdata[BSR_LINK];
               an_d    = cmd_rdata[BSR_AN_DONE];
               lc_d    = cmd_rdata[BSR_LINK] ^ link_q;
               sv_d    = 1'b1;
               err_d   = 1'b0;
            end
         end
         StUpdate, StFail: begin
            ivl_d   = IvlW'(P_POLL_INTERVAL - 1);
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Poll FSM, interval counter and status registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         ivl_q   <= '0;
         pend_q  <= 1'b0;
         bcnt_q  <= '0;
         phy_q   <= '0;
         link_q  <= 1'b0;
         an_q    <= 1'b0;
         sv_q    <= 1'b0;
         lc_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ivl_q   <= ivl_d;
         pend_q  <= pend_d;
         bcnt_q  <= bcnt_d;
         phy_q   <= phy_d;
         link_q  <= link_d;
         an_q    <= an_d;
         sv_q    <= sv_d;
         lc_q    <= lc_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_mdio_link_poller.sv
// Directed bench for mdio_link_poller with a small axi_eth MDIO responder.
module tb_mdio_link_poller;

   localparam int unsigned AW       = 13;
   localparam int unsigned DW       = 32;
   localparam int unsigned INTERVAL = 200;
   localparam int unsigned TIMEOUT  = 4096;
   localparam int unsigned BUSY_MAX = 64;
   localparam int unsigned WR_GAP   = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          enable = 1'b0;
   logic          force_poll = 1'b0;
   logic          read_done = 1'b0;
   logic [DW-1:0] axi_read_data = '0;
   logic          do_axi_write, do_axi_read;
   logic [AW-1:0] axi_write_addr, axi_read_addr;
   logic [DW-1:0] axi_write_data;
   logic [15:0]   phy_status;
   logic          link_up, an_done, status_valid, link_change, err, busy;

   always #5 clk = ~clk;

   mdio_link_poller #(
      .P_AXI_ADDR_WIDTH(AW),
      .P_AXI_DATA_WIDTH(DW),
      .P_PHY_ADDR      (0),
      .P_POLL_INTERVAL (INTERVAL),
      .P_WR_GAP        (WR_GAP),
      .P_TIMEOUT       (TIMEOUT),
      .P_BUSY_MAX      (BUSY_MAX)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .enable        (enable),
      .force_poll    (force_poll),
      .do_axi_write  (do_axi_write),
      .axi_write_addr(axi_write_addr),
      .axi_write_data(axi_write_data),
      .do_axi_read   (do_axi_read),
      .axi_read_addr (axi_read_addr),
      .axi_read_data (axi_read_data),
      .read_done     (read_done),
      .phy_status    (phy_status),
      .link_up       (link_up),
      .an_done       (an_done),
      .status_valid  (status_valid),
      .link_change   (link_change),
      .err           (err),
      .busy          (busy)
   );

   // Responder configuration (written by the stimulus only)
   int          cfg_busy_n = 0;   // -1: MDIOCTRL reads busy forever
   logic [15:0] cfg_data = 16'h0;
   logic        cfg_mute = 1'b0;

   // Responder/monitor state (written by the responder only)
   int            cyc = 0, ctrl_reads = 0, data_reads = 0, polls_done = 0;
   int            sv_pulses = 0, lc_pulses = 0, busy_seen = 0, rd_pend = 0;
   int            idle_run = 0, last_idle = 0, last_rd_cyc = 0, err_rise_cyc = 0;
   logic          busy_prev = 1'b0, err_prev = 1'b0;
   logic [DW-1:0] rd_resp = '0;
   logic [AW-1:0] wr_addr_log[$];
   logic [DW-1:0] wr_data_log[$];

   // axi_eth responder: read_done three cycles after each read strobe
   always @(negedge clk) begin
      cyc++;
      read_done = 1'b0;
      if (rd_pend > 0) begin
         rd_pend--;
         if (rd_pend == 0) begin
            read_done     = 1'b1;
            axi_read_data = rd_resp;
         end
      end
      if (do_axi_write) begin
         wr_addr_log.push_back(axi_write_addr);
         wr_data_log.push_back(axi_write_data);
         if (axi_write_addr == 13'h07E4) busy_seen = 0;
      end
      if (do_axi_read) begin
         last_rd_cyc = cyc;
         if (axi_read_addr == 13'h07F0) begin
            ctrl_reads++;
            rd_resp = ((cfg_busy_n < 0) || (busy_seen < cfg_busy_n)) ? 32'h9 : 32'h8;
            busy_seen++;
         end else begin
            data_reads++;
            rd_resp = {16'hDEAD, cfg_data};
         end
         if (!cfg_mute) rd_pend = 3;
      end
      if (status_valid) sv_pulses++;
      if (link_change) lc_pulses++;
      if (busy_prev && !busy) polls_done++;
      if (!busy) idle_run++;
      else if (idle_run > 0) begin
         last_idle = idle_run;
         idle_run  = 0;
      end
      if (err && !err_prev) err_rise_cyc = cyc;
      busy_prev = busy;
      err_prev  = err;
   end

   typedef struct {
      int          busy_n;
      logic [15:0] data;
      logic [15:0] exp_phy;
      logic        exp_link;
      logic        exp_an;
      logic        exp_err;
      int          exp_sv;
      int          exp_lc;
      int          exp_ctrl;
      int          exp_data;
   } vec_t;

   vec_t vecs[6];
   int   n_vec = 0, n_mis = 0;
   int   b_ctrl, b_data, b_sv, b_lc, b_polls, n;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_polls(input int target);
      int k = 0;
      while (polls_done < target && k < 20000) begin
         @(negedge clk);
         k++;
      end
      check("poll_completes", polls_done, target);
   endtask

   initial begin
      //          busy  data      phy       lnk an  err sv lc ctrl data
      vecs[0] = '{0,  16'h7849, 16'h7849, 0,  0,  0,  1, 0, 1,  1};
      vecs[1] = '{0,  16'h786D, 16'h786D, 1,  1,  0,  1, 1, 1,  1};
      vecs[2] = '{0,  16'h786D, 16'h786D, 1,  1,  0,  1, 0, 1,  1};
      vecs[3] = '{3,  16'h7849, 16'h7849, 0,  0,  0,  1, 1, 4,  1};
      vecs[4] = '{-1, 16'h1234, 16'h7849, 0,  0,  1,  0, 0, 64, 0};
      vecs[5] = '{0,  16'h786D, 16'h786D, 1,  1,  0,  1, 1, 1,  1};

      cfg_busy_n = vecs[0].busy_n;
      cfg_data   = vecs[0].data;
      rst        = 1'b1;
      enable     = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_outputs", 32'(|{do_axi_write, axi_write_addr, axi_write_data, do_axi_read,
            axi_read_addr, phy_status, link_up, an_done, status_valid, link_change, err, busy}),
            32'd0);
      rst = 1'b0;

      for (int k = 0; k < 6; k++) begin
         cfg_busy_n = vecs[k].busy_n;
         cfg_data   = vecs[k].data;
         b_ctrl     = ctrl_reads;
         b_data     = data_reads;
         b_sv       = sv_pulses;
         b_lc       = lc_pulses;
         wait_polls(k + 1);
         check($sformatf("v%0d_phy_status", k), phy_status, vecs[k].exp_phy);
         check($sformatf("v%0d_link_up", k), link_up, vecs[k].exp_link);
         check($sformatf("v%0d_an_done", k), an_done, vecs[k].exp_an);
         check($sformatf("v%0d_err", k), err, vecs[k].exp_err);
         check($sformatf("v%0d_status_valid", k), sv_pulses - b_sv, vecs[k].exp_sv);
         check($sformatf("v%0d_link_change", k), lc_pulses - b_lc, vecs[k].exp_lc);
         check($sformatf("v%0d_ctrl_reads", k), ctrl_reads - b_ctrl, vecs[k].exp_ctrl);
         check($sformatf("v%0d_data_reads", k), data_reads - b_data, vecs[k].exp_data);
      end

      check("wr0_addr", 32'(wr_addr_log[0]), 32'h07E4);
      check("wr0_data", wr_data_log[0], 32'h0000_0401);
      check("wr1_addr", 32'(wr_addr_log[1]), 32'h07F0);
      check("wr1_data", wr_data_log[1], 32'h0000_0009);
      check("poll_spacing", last_idle, INTERVAL);

      // read_done withheld: FAIL lands exactly TIMEOUT cycles after the strobe
      cfg_busy_n = 0;
      cfg_mute   = 1'b1;
      b_ctrl     = ctrl_reads;
      wait_polls(7);
      check("timeout_err", err, 1);
      check("timeout_link_up", link_up, 0);
      check("timeout_ctrl_reads", ctrl_reads - b_ctrl, 1);
      check("timeout_latency", err_rise_cyc - last_rd_cyc, TIMEOUT);
      cfg_mute = 1'b0;

      // enable low: only forced polls, repeated requests collapse into one
      enable   = 1'b0;
      cfg_data = 16'h786D;
      b_polls  = polls_done;
      repeat (300) @(negedge clk);
      check("no_periodic_poll", polls_done, b_polls);
      force_poll = 1'b1;
      @(negedge clk);
      force_poll = 1'b0;
      n = 0;
      while (!busy && n < 10) begin
         @(negedge clk);
         n++;
      end
      check("force_starts_poll", busy, 1);
      repeat (4) @(negedge clk);
      force_poll = 1'b1;
      @(negedge clk);
      force_poll = 1'b0;
      repeat (2) @(negedge clk);
      force_poll = 1'b1;
      @(negedge clk);
      force_poll = 1'b0;
      wait_polls(b_polls + 2);
      repeat (400) @(negedge clk);
      check("one_extra_poll", polls_done, b_polls + 2);
      check("busy_after_force", busy, 0);
      check("err_cleared", err, 0);

      // synchronous reset in the middle of the second write gap
      force_poll = 1'b1;
      @(negedge clk);
      force_poll = 1'b0;
      n = 0;
      while (!(do_axi_write && axi_write_addr == 13'h07F0) && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("ctrl_write_seen", do_axi_write, 1);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("reset_mid_gap2", 32'(|{do_axi_write, axi_write_addr, axi_write_data, do_axi_read,
            axi_read_addr, phy_status, link_up, an_done, status_valid, link_change, err, busy}),
            32'd0);
      rst = 1'b0;
      repeat (50) @(negedge clk);
      check("idle_after_reset", busy, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule

// File: doc/mdio_link_poller.md
Name: mdio_link_poller

Overview:
- Periodic PHY link monitor that sits directly upstream of axi_eth and drives its simple command port (do_axi_write / do_axi_read / read_done).
- Each poll runs one MDIO read of PHY register 1 (Basic Status) through the AXI Ethernet Lite MDIO registers: program MDIOADDR, trigger MDIOCTRL, poll until not busy, read MDIORD.
- Publishes link-up and auto-negotiation-complete status to the rest of the design.

Parameters:
- P_AXI_ADDR_WIDTH, 13, command address width; matches axi_eth.
- P_AXI_DATA_WIDTH, 32, command data width; matches axi_eth.
- P_PHY_ADDR, 0, 5-bit MDIO PHY address.
- P_POLL_INTERVAL, 1000000, clk cycles from the end of one poll to the start of the next.
- P_WR_GAP, 16, idle cycles after each write pulse (the write path has no completion signal).
- P_TIMEOUT, 4096, maximum cycles to wait for read_done on any single read.
- P_BUSY_MAX, 64, maximum MDIOCTRL busy polls per transaction.

Ports:
- clk  in  1  system clock, shared with axi_eth.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  level; 1 allows periodic polling.
- force_poll  in  1  one-cycle request to start a poll immediately.
- do_axi_write  out  1  one-cycle write strobe to axi_eth.
- axi_write_addr  out  P_AXI_ADDR_WIDTH  write address.
- axi_write_data  out  P_AXI_DATA_WIDTH  write data.
- do_axi_read  out  1  one-cycle read strobe to axi_eth.
- axi_read_addr  out  P_AXI_ADDR_WIDTH  read address.
- axi_read_data  in  P_AXI_DATA_WIDTH  read data; valid in the read_done cycle.
- read_done  in  1  read completion pulse from axi_eth.
- phy_status  out  16  last successfully read value of PHY register 1.
- link_up  out  1  phy_status[2].
- an_done  out  1  phy_status[5].
- status_valid  out  1  one-cycle pulse when phy_status is updated.
- link_change  out  1  one-cycle pulse, coincident with status_valid, when link_up toggles.
- err  out  1  sticky; cleared by the next successful poll.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values: all outputs 0, including addresses and data; state = IDLE; interval counter = 0, so the first poll starts as soon as enable is high.
- Register addresses: MDIOADDR 0x07E4, MDIORD 0x07EC, MDIOCTRL 0x07F0.
- MDIOADDR word: bit10 = 1 (read), [9:5] = P_PHY_ADDR, [4:0] = 1. With P_PHY_ADDR = 0 the word is 0x00000401.
- MDIOCTRL trigger word: 0x00000009 (bit3 enable, bit0 status/busy).
- Strobes are registered and high for exactly one cycle. Address and data are held stable from the strobe cycle until the next strobe.
- States and transitions:
  - IDLE: go to WR_ADDR when (enable and interval counter expired) or a force_poll is pending.
  - WR_ADDR: strobe MDIOADDR write -> GAP1.
  - GAP1: wait P_WR_GAP cycles -> WR_CTRL.
  - WR_CTRL: strobe MDIOCTRL write -> GAP2.
  - GAP2: wait P_WR_GAP cycles -> BUSY_RD.
  - BUSY_RD: strobe read of MDIOCTRL -> BUSY_WAIT.
  - BUSY_WAIT: on read_done, if data bit0 = 0 -> DATA_RD; else increment the busy count and return to BUSY_RD. Busy count reaching P_BUSY_MAX -> FAIL.
  - DATA_RD: strobe read of MDIORD -> DATA_WAIT.
  - DATA_WAIT: on read_done -> UPDATE.
  - UPDATE (one cycle): load phy_status from axi_read_data[15:0], pulse status_valid, clear err, restart the interval counter -> IDLE.
  - FAIL (one cycle): set err, clear link_up and an_done (phy_status keeps its old value), restart the interval counter -> IDLE.
- Timeout: a cycle counter restarts on every read strobe. No read_done within P_TIMEOUT cycles in BUSY_WAIT or DATA_WAIT -> FAIL.
- read_done arriving in any state other than BUSY_WAIT or DATA_WAIT is ignored.
- force_poll while busy: latched into one pending flag and serviced on return to IDLE. Multiple requests collapse into one. force_poll starts a poll even when enable = 0.
- enable deasserted mid-poll: the poll completes normally; no new periodic poll starts afterwards.
- link_change compares the new phy_status[2] with the previous link_up. It also fires on the first successful poll when the link is up (previous link_up = 0).
- Interval counter: 0 to P_POLL_INTERVAL-1, counts only in IDLE. Width is $clog2(P_POLL_INTERVAL+1).
- rst asserted mid-poll: abort immediately; strobes low in the following cycle; all state and outputs return to reset values.

Decomposition:
- Shared package eth_pkg holds:
  - the MDIO register offset constants (MDIO_ADDR, MDIO_WR, MDIO_RD, MDIO_CTRL);
  - the MDIOCTRL bit positions (CTRL_BUSY = 0, CTRL_EN = 3);
  - the PHY register 1 bit positions (BSR_LINK = 2, BSR_AN_DONE = 5);
  - the poller state enum.
- One sub-module: mdio_cmd_seq, which issues a single write or read with gap and timeout handling and returns done/timeout/rdata.
- The top level holds the poll FSM, the interval counter and the status registers.

Test Plan:
- Reset release, enable = 1, bench model returns busy = 0 then MDIORD = 0x7849 -> writes 0x401 to 0x7E4, then 0x9 to 0x7F0; phy_status = 0x7849; an_done = 0; link_up = 0; status_valid pulses once; err = 0.
- Model returns MDIORD = 0x786D -> link_up = 1, an_done = 1, link_change pulse; next poll also returns 0x786D -> status_valid pulse with no link_change; polls spaced P_POLL_INTERVAL cycles apart (set to 200 for the bench).
- MDIOCTRL reads busy = 1 three times, then 0 -> exactly 4 MDIOCTRL reads followed by 1 MDIORD read; status updated.
- Busy held at 1 permanently -> 64 MDIOCTRL reads, then err = 1 and link_up = 0; a following good poll clears err.
- read_done withheld -> FAIL exactly P_TIMEOUT cycles after the read strobe; err = 1.
- enable = 0, force_poll pulsed twice during a poll -> exactly one extra poll runs; busy low afterwards; rst asserted mid-GAP2 -> all outputs 0 next cycle.
